ov7670_sccb_config: RTL and testbench

Power-up configuration sequencer for the OV7670 camera feeding the frame-buffer capture path. On a START pulse it walks a fixed 8-entry register table and issues one 3-phase SCCB write per entry: device address, register address, then data. An extra settle delay follows the soft-reset entry. It owns the camera's SIOC/SIOD pins, so the capture controller receives QCIF RGB565 without an external microcontroller. It runs on the 25 MHz VGA/read-side clock.

---
 rtl/ov7670_sccb_config.sv | 145 ++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: power-up SCCB write sequencer for the OV7670 camera.
// Ports: CLK/RESET (async active-low) clock and reset; START one-cycle launch pulse;
// SIOC, SIOD_OUT, SIOD_OE drive the SCCB pins; BUSY/DONE sequence status; IDX table entry.
module ov7670_sccb_config #(
  parameter int          CLK_DIV    = 63,
  parameter int          RESET_WAIT = 25000,
  parameter logic [7:0]  DEV_ADDR   = 8'h42
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  output logic       SIOC,
  output logic       SIOD_OUT,
  output logic       SIOD_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] IDX
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int WW = $clog2(RESET_WAIT + 1);
  localparam logic [15:0] TABLE [8] = '{16'h1280, 16'h11C0, 16'h0C08, 16'h120C,
                                        16'h40D0, 16'h140B, 16'h1E30, 16'h4200};
  typedef enum logic [3:0] {IDLE, LOAD, START_A, START_B, BIT, STOP_A, STOP_B, STOP_C,
                            GAP, WAIT, FINISH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [1:0] qtr_q, qtr_d;
  logic [4:0] bit_q, bit_d;
  logic [26:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d, sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
  logic tick, ack;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    wcnt_d = wcnt_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    shift_d = shift_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = done_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = LOAD;
        idx_d = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      LOAD: begin
        // don't-care slots carry 1 so the released line matches the pull-up
        shift_d = {DEV_ADDR, 1'b1, TABLE[idx_q][15:8], 1'b1, TABLE[idx_q][7:0], 1'b1};
        state_d = START_A;
      end
      START_A: if (tick) state_d = START_B;
      START_B: if (tick) begin
        state_d = BIT;
        qtr_d = '0;
        bit_d = '0;
      end
      BIT: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          bit_d = bit_q + 5'd1;
          shift_d = shift_q << 1;
          if (bit_q == 5'd26) state_d = STOP_A;
        end
      end
      STOP_A: if (tick) state_d = STOP_B;
      STOP_B: if (tick) state_d = STOP_C;
      STOP_C: if (tick) begin
        state_d = GAP;
        qtr_d = '0;
      end
      GAP: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          if (idx_q == 3'd0) begin
            state_d = WAIT;
            wcnt_d = '0;
          end else if (idx_q == 3'd7) state_d = FINISH;
          else begin
            idx_d = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      WAIT: if (wcnt_q == WW'(RESET_WAIT - 1)) begin
        idx_d = 3'd1;
        state_d = LOAD;
      end else wcnt_d = wcnt_q + 1'b1;
      FINISH: begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // pin values are derived from the next state so they line up with it
    ack = bit_d == 5'd8 || bit_d == 5'd17 || bit_d == 5'd26;
    sioc_d = !(state_d == START_B || state_d == STOP_A || (state_d == BIT && !qtr_d[1]));
    siod_d = state_d inside {START_A, START_B, STOP_A, STOP_B} ? 1'b0 :
             state_d == BIT ? shift_d[26] : 1'b1;
    oe_d = state_d inside {START_A, START_B, BIT, STOP_A, STOP_B, STOP_C} &&
           !(state_d == BIT && ack);
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wcnt_q <= '0;
      qtr_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sioc_q <= 1'b1;
      siod_q <= 1'b1;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sioc_q <= sioc_d;
      siod_q <= siod_d;
      oe_q <= oe_d;
    end
  end
  assign SIOC = sioc_q;
  assign SIOD_OUT = siod_q;
  assign SIOD_OE = oe_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign IDX = idx_q;
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: bench for the OV7670 SCCB sequencer at quarter dividers 2 and 3.
module tb_ov7670_sccb_config;
  logic CLK = 1'b0, RESET = 1'b0, START = 1'b0;
  logic sioc [2], siod [2], oe [2], busy [2], done [2];
  logic [2:0] idx [2];
  int divs [2] = '{2, 3};
  localparam int RW = 20;
  logic [7:0] tab_reg [8] = '{8'h12, 8'h11, 8'h0C, 8'h12, 8'h40, 8'h14, 8'h1E, 8'h42};
  logic [7:0] tab_dat [8] = '{8'h80, 8'hC0, 8'h08, 8'h0C, 8'hD0, 8'h0B, 8'h30, 8'h00};
  int checks = 0, failures = 0, cyc = 0;
  logic pline [2], psioc [2], inframe [2];
  int nbits [2], ntx [2], nst [2], last_chg [2], last_st [2];
  logic [26:0] sh [2];

  always #5 CLK = ~CLK;

  ov7670_sccb_config #(.CLK_DIV(2), .RESET_WAIT(RW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SIOC(sioc[0]), .SIOD_OUT(siod[0]),
    .SIOD_OE(oe[0]), .BUSY(busy[0]), .DONE(done[0]), .IDX(idx[0]));
  ov7670_sccb_config #(.CLK_DIV(3), .RESET_WAIT(RW)) dut3 (
    .CLK(CLK), .RESET(RESET), .START(START), .SIOC(sioc[1]), .SIOD_OUT(siod[1]),
    .SIOD_OE(oe[1]), .BUSY(busy[1]), .DONE(done[1]), .IDX(idx[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bus-level observer: decodes start/stop conditions and bytes from the wire
  task automatic mon();
    logic line;
    for (int i = 0; i < 2; i++) begin
      line = oe[i] ? siod[i] : 1'b1;
      if (!RESET) begin
        inframe[i] = 1'b0;
        nbits[i] = 0;
      end else begin
        if (line !== pline[i]) begin
          if (sioc[i] && psioc[i] && !line && !inframe[i]) begin
            inframe[i] = 1'b1;
            nbits[i] = 0;
            if (nst[i] == 1) chk("gap_after_w0", cyc - last_st[i], 1 + 117 * divs[i] + RW);
            else if (nst[i] > 1) chk("gap_write", cyc - last_st[i], 1 + 117 * divs[i]);
            last_st[i] = cyc;
            nst[i]++;
          end else if (sioc[i] && psioc[i] && line && inframe[i] && nbits[i] == 27) begin
            inframe[i] = 1'b0;
            chk("tx_bytes", {sh[i][26:19], sh[i][17:10], sh[i][8:1]},
                {8'h42, tab_reg[ntx[i] & 7], tab_dat[ntx[i] & 7]});
            ntx[i]++;
          end else chk("siod_change_sioc_low", sioc[i], 0);
          last_chg[i] = cyc;
        end
        if (sioc[i] && !psioc[i] && inframe[i] && nbits[i] < 27) begin
          if (nbits[i] inside {8, 17, 26}) chk("ack_oe_low", oe[i], 0);
          else chk("setup_2q", cyc - last_chg[i] >= 2 * divs[i], 1);
          sh[i] = {sh[i][25:0], line};
          nbits[i]++;
        end
      end
      pline[i] = line;
      psioc[i] = sioc[i];
    end
    cyc++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      mon();
    end
  endtask

  task automatic run_sequence();
    int tp, e;
    tp = 725 + $urandom_range(0, 234);
    for (int i = 0; i < 2; i++) begin
      ntx[i] = 0;
      nst[i] = 0;
    end
    START = 1'b1;
    step(1);
    START = 1'b0;
    chk("done_clear", done[0], 0);
    for (int t = 0; t < 1901; t++) begin
      e = t < 255 ? 0 : (1 + (t - 255) / 235 > 7 ? 7 : 1 + (t - 255) / 235);
      chk("busy_high", busy[0], 1);
      chk("idx_seq", idx[0], e);
      START = (t == tp);
      step(1);
    end
    START = 1'b0;
    chk("busy_fall", busy[0], 0);
    chk("done_rise", done[0], 1);
    chk("idx_end", idx[0], 7);
    for (int k = 0; k < 2000 && busy[1] === 1'b1; k++) step(1);
    chk("div3_idle", busy[1], 0);
    chk("div3_done", done[1], 1);
    for (int i = 0; i < 2; i++) begin
      chk("tx_count", ntx[i], 8);
      chk("start_count", nst[i], 8);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pline[i] = 1'b1;
      psioc[i] = 1'b1;
      inframe[i] = 1'b0;
      nbits[i] = 0;
      ntx[i] = 0;
      nst[i] = 0;
      last_chg[i] = 0;
      last_st[i] = 0;
      sh[i] = '0;
    end
    step(3);
    chk("por_sioc", sioc[0], 1);
    chk("por_oe", oe[0], 0);
    chk("por_busy", busy[0], 0);
    RESET = 1'b1;
    step(2);
    START = 1'b1;
    step(1);
    START = 1'b0;
    step($urandom_range(8, 700));
    #2 RESET = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sioc", sioc[i], 1);
      chk("rst_siod", siod[i], 1);
      chk("rst_oe", oe[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_idx", idx[i], 0);
    end
    step(2);
    RESET = 1'b1;
    step(2);
    run_sequence();
    step($urandom_range(1, 30));
    run_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
